// File: rtl/gemini_defs.sv
// Shared definitions for the gemini fetch path: instruction-queue entry layout
// and pop-request encodings.
package gemini_defs;

  localparam int IQ_ENTRY_W  = 65;
  localparam int IQ_INST_LSB = 0;
  localparam int IQ_PC_LSB   = 32;
  localparam int IQ_ADEL_BIT = 64;

  localparam logic [1:0] POP_NONE = 2'd0;
  localparam logic [1:0] POP_ONE  = 2'd1;
  localparam logic [1:0] POP_TWO  = 2'd2;

  typedef logic [IQ_ENTRY_W-1:0] iq_entry_t;

  function automatic iq_entry_t iq_pack(input logic adel, input logic [31:0] pc,
                                        input logic [31:0] inst);
    iq_entry_t e;
    e = '0;
    e[IQ_ADEL_BIT]       = adel;
    e[IQ_PC_LSB +: 32]   = pc;
    e[IQ_INST_LSB +: 32] = inst;
    return e;
  endfunction

  // Decode never consumes more than two per cycle; an encoding of 3 means 2.
  function automatic logic [1:0] pop_sat(input logic [1:0] req);
    case (req)
      POP_NONE: return POP_NONE;
      POP_ONE:  return POP_ONE;
      default:  return POP_TWO;
    endcase
  endfunction

endpackage

// File: rtl/iq_ram.sv
// Entry storage for inst_queue: multi-write, asynchronous multi-read register
// array with no reset. Callers keep simultaneous write addresses distinct.
module iq_ram
  import gemini_defs::*;
#(
  parameter int DEPTH     = 16,
  parameter int PTR_W     = 4,
  parameter int NUM_PORTS = 2
) (
  input  logic                                  clk,
  input  logic [NUM_PORTS-1:0]                  we,
  input  logic [NUM_PORTS-1:0][PTR_W-1:0]       waddr,
  input  logic [NUM_PORTS-1:0][IQ_ENTRY_W-1:0]  wdata,
  input  logic [NUM_PORTS-1:0][PTR_W-1:0]       raddr,
  output logic [NUM_PORTS-1:0][IQ_ENTRY_W-1:0]  rdata
);

  logic [IQ_ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (we[p]) mem_q[waddr[p]] <= wdata[p];
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
    assign rdata[g] = mem_q[raddr[g]];
  end

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction fetch queue between the I-cache and decode: takes up
// to two fetched instructions per cycle and presents the oldest two.
module inst_queue
  import gemini_defs::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_ok_1,
  input  logic             in_ok_2,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst_1,
  input  logic [31:0]      in_inst_2,
  input  logic             in_adel,
  output logic             in_ready,
  output logic             out_valid_1,
  output logic             out_valid_2,
  output logic [31:0]      out_pc_1,
  output logic [31:0]      out_pc_2,
  output logic [31:0]      out_inst_1,
  output logic [31:0]      out_inst_2,
  output logic             out_adel_1,
  output logic             out_adel_2,
  input  logic [1:0]       out_pop,
  output logic [PTR_W:0]   count
);

  localparam int CNT_W     = PTR_W + 1;
  localparam int NUM_SLOTS = 2;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       push_n, pop_req, pop_n;

  logic [NUM_SLOTS-1:0]                 ram_we;
  logic [NUM_SLOTS-1:0][PTR_W-1:0]      ram_waddr;
  logic [NUM_SLOTS-1:0][IQ_ENTRY_W-1:0] ram_wdata;
  logic [NUM_SLOTS-1:0][PTR_W-1:0]      ram_raddr;
  logic [NUM_SLOTS-1:0][IQ_ENTRY_W-1:0] ram_rdata;
  logic [NUM_SLOTS-1:0][IQ_ENTRY_W-1:0] slot_data;
  logic [NUM_SLOTS-1:0]                 slot_vld;

  // Accept only when two slots are free so the cache never sees a partial accept.
  assign in_ready = (count_q <= CNT_W'(DEPTH - 2));

  always_comb begin
    push_n = 2'd0;
    if (in_ready && in_ok_1) push_n = (in_ok_2 && !in_adel) ? 2'd2 : 2'd1;
  end

  always_comb begin
    pop_req = pop_sat(out_pop);
    pop_n   = pop_req;
    if (CNT_W'(pop_req) > count_q) pop_n = count_q[1:0];
  end

  always_comb begin
    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    ram_we       = '0;
    ram_we[0]    = (push_n != 2'd0) && !flush;
    ram_we[1]    = (push_n == 2'd2) && !flush;
    ram_waddr[0] = tail_q;
    ram_waddr[1] = tail_q + PTR_W'(1);
    ram_wdata[0] = iq_pack(in_adel, in_pc, in_inst_1);
    ram_wdata[1] = iq_pack(1'b0, in_pc + 32'd4, in_inst_2);
    ram_raddr[0] = head_q;
    ram_raddr[1] = head_q + PTR_W'(1);
  end

  iq_ram #(
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W),
    .NUM_PORTS (NUM_SLOTS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Invalid slots read as zero so stale storage never leaks to decode.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign slot_vld[g]  = (count_q > CNT_W'(g));
    assign slot_data[g] = slot_vld[g] ? ram_rdata[g] : '0;
  end

  assign out_valid_1 = slot_vld[0];
  assign out_valid_2 = slot_vld[1];
  assign out_adel_1  = slot_data[0][IQ_ADEL_BIT];
  assign out_adel_2  = slot_data[1][IQ_ADEL_BIT];
  assign out_pc_1    = slot_data[0][IQ_PC_LSB +: 32];
  assign out_pc_2    = slot_data[1][IQ_PC_LSB +: 32];
  assign out_inst_1  = slot_data[0][IQ_INST_LSB +: 32];
  assign out_inst_2  = slot_data[1][IQ_INST_LSB +: 32];
  assign count       = count_q;

endmodule
